// File: rtl/miriscv_lsu.sv
// rtl/miriscv_lsu.sv - load/store unit between the core pipeline and a req/rvalid data bus
// Three-state access sequencer: IDLE issues, WAIT counts toward bus timeout, DONE releases the stall.
module miriscv_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam int CW = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          we_q, we_d;

  logic        size_legal, misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size_legal = (lsu_size_i == 3'b000) || (lsu_size_i == 3'b001) || (lsu_size_i == 3'b010) ||
                 (!lsu_we_i && ((lsu_size_i == 3'b100) || (lsu_size_i == 3'b101)));
    misaligned = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                 ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    case (lsu_size_i[1:0])
      2'b00:   begin be_c = 4'b0001 << lsu_addr_i[1:0]; wdata_c = {4{lsu_data_i[7:0]}}; end
      2'b01:   begin be_c = lsu_addr_i[1] ? 4'b1100 : 4'b0011; wdata_c = {2{lsu_data_i[15:0]}}; end
      default: begin be_c = 4'b1111; wdata_c = lsu_data_i; end
    endcase
  end

  // Load extraction uses the low address bits and size captured when the request was issued.
  always_comb begin
    case (addr_q)
      2'd0:    ld_byte = data_rdata_i[7:0];
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      3'b000:  load_c = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_c = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_c = {24'd0, ld_byte};
      3'b101:  load_c = {16'd0, ld_half};
      default: load_c = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    addr_d          = addr_q;
    size_d          = size_q;
    we_d            = we_q;
    lsu_stall_req_o = 1'b0;
    lsu_misalign_o  = 1'b0;
    lsu_err_o       = 1'b0;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_addr_o     = 32'd0;
    data_wdata_o    = 32'd0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            if (!size_legal) begin
              lsu_err_o = 1'b1;
            end else if (misaligned) begin
              lsu_misalign_o = 1'b1;
            end else begin
              data_req_o      = 1'b1;
              data_we_o       = lsu_we_i;
              data_be_o       = be_c;
              data_addr_o     = {lsu_addr_i[31:2], 2'b00};
              data_wdata_o    = wdata_c;
              lsu_stall_req_o = 1'b1;
              cnt_d           = '0;
              addr_d          = lsu_addr_i[1:0];
              size_d          = lsu_size_i;
              we_d            = lsu_we_i;
              state_d         = WAIT;
            end
          end
        end
        WAIT: begin
          lsu_stall_req_o = 1'b1;
          // A response in the timeout cycle still completes the access normally.
          if (data_rvalid_i) begin
            if (!we_q) data_d = load_c;
            state_d = DONE;
          end else if (cnt_q == CW'(BUS_TIMEOUT)) begin
            lsu_err_o = 1'b1;
            data_d    = 32'd0;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 32'd0;
      addr_q  <= 2'd0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  assign lsu_data_o = data_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb/tb_miriscv_lsu.sv - directed scoreboard bench for miriscv_lsu
// Expected load results are queued when a request is issued and popped in the DONE cycle.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, data_rvalid_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, data_rdata_i;
  logic [31:0] lsu_data_o, data_addr_o, data_wdata_o;
  logic        lsu_stall_req_o, lsu_misalign_o, lsu_err_o, data_req_o, data_we_o;
  logic [3:0]  data_be_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] last_data = 32'd0;

  miriscv_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_misalign_o(lsu_misalign_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> {a[1:0], 3'b000};
    b  = sh[7:0];
    h  = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  task automatic sb_check(input string tag);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h", tag, lsu_data_o);
    end else begin
      n_checks--;
      check(tag, lsu_data_o, sb.pop_front());
    end
  endtask

  // One full access: issue, 'delay' silent WAIT cycles, response, DONE with request still held.
  task automatic access(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int delay, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = wd;
    if (!we) last_data = load_model(sz, a, rd);
    sb.push_back(last_data);
    #1;
    check({tag, "_req"},   32'(data_req_o), 32'd1);
    check({tag, "_we"},    32'(data_we_o), 32'(we));
    check({tag, "_be"},    32'(data_be_o), 32'(exp_be));
    check({tag, "_addr"},  data_addr_o, {a[31:2], 2'b00});
    check({tag, "_wdata"}, data_wdata_o, exp_wd);
    check({tag, "_stall"}, 32'(lsu_stall_req_o), 32'd1);
    step();
    for (int i = 0; i < delay; i++) begin
      check({tag, "_wait_stall"}, 32'(lsu_stall_req_o), 32'd1);
      check({tag, "_wait_req"},   32'(data_req_o), 32'd0);
      step();
    end
    data_rvalid_i = 1'b1; data_rdata_i = rd;
    #1;
    check({tag, "_rv_stall"}, 32'(lsu_stall_req_o), 32'd1);
    check({tag, "_rv_err"},   32'(lsu_err_o), 32'd0);
    step();
    data_rvalid_i = 1'b0; data_rdata_i = 32'hxxxx_xxxx;
    check({tag, "_done_stall"}, 32'(lsu_stall_req_o), 32'd0);
    check({tag, "_done_req"},   32'(data_req_o), 32'd0);
    sb_check({tag, "_data"});
    step();
    lsu_req_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010;
    lsu_addr_i = 32'h0; lsu_data_i = 32'h0; data_rdata_i = 32'h0; data_rvalid_i = 1'b0;
    #12;
    check("rst_req",   32'(data_req_o), 32'd0);
    check("rst_stall", 32'(lsu_stall_req_o), 32'd0);
    check("rst_data",  lsu_data_o, 32'd0);
    check("rst_be",    32'(data_be_o), 32'd0);
    lsu_req_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();

    access("lb",   1'b0, 3'b000, 32'h103, 32'h1122_3344, 32'h80FF_1234, 0, 4'b1000, 32'h4444_4444);
    access("sh",   1'b1, 3'b001, 32'h22,  32'h0000_ABCD, 32'h0,         1, 4'b1100, 32'hABCD_ABCD);
    access("lhu",  1'b0, 3'b101, 32'h42,  32'h0,         32'h8001_7F00, 2, 4'b1100, 32'h0);
    access("lbu",  1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_9A00, 0, 4'b0010, 32'h0);
    access("lw_to",1'b0, 3'b010, 32'h0,   32'h0,         32'hDEAD_BEEF, 4, 4'b1111, 32'h0);
    access("sw",   1'b1, 3'b010, 32'h4,   32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'hCAFE_F00D);
    access("sb",   1'b1, 3'b000, 32'h3,   32'h0000_005A, 32'h0,         0, 4'b1000, 32'h5A5A_5A5A);

    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h6;
    #1;
    check("mis_pulse", 32'(lsu_misalign_o), 32'd1);
    check("mis_req",   32'(data_req_o), 32'd0);
    check("mis_stall", 32'(lsu_stall_req_o), 32'd0);
    check("mis_err",   32'(lsu_err_o), 32'd0);
    lsu_size_i = 3'b011;
    #1;
    check("ill_err", 32'(lsu_err_o), 32'd1);
    check("ill_mis", 32'(lsu_misalign_o), 32'd0);
    check("ill_req", 32'(data_req_o), 32'd0);
    step();
    lsu_we_i = 1'b1; lsu_size_i = 3'b100; lsu_addr_i = 32'h8;
    #1;
    check("st_bu_err", 32'(lsu_err_o), 32'd1);
    check("st_bu_req", 32'(data_req_o), 32'd0);
    lsu_req_i = 1'b0;
    step();

    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h10;
    step();
    step();
    rst_i = 1'b1;
    #1;
    check("mid_rst_data",  lsu_data_o, 32'd0);
    check("mid_rst_stall", 32'(lsu_stall_req_o), 32'd0);
    check("mid_rst_err",   32'(lsu_err_o), 32'd0);
    check("mid_rst_req",   32'(data_req_o), 32'd0);
    step();
    rst_i = 1'b0; lsu_req_i = 1'b0; last_data = 32'd0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    #1;
    check("post_rst_stall", 32'(lsu_stall_req_o), 32'd0);
    check("post_rst_err",   32'(lsu_err_o), 32'd0);
    step();
    data_rvalid_i = 1'b0;
    check("post_rst_data", lsu_data_o, 32'd0);
    check("post_rst_req",  32'(data_req_o), 32'd0);

    access("lh", 1'b0, 3'b001, 32'h40, 32'h0, 32'h1234_8001, 0, 4'b0011, 32'h0);

    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b101; lsu_addr_i = 32'h40;
    last_data = 32'd0;
    sb.push_back(32'd0);
    #1;
    check("to_req", 32'(data_req_o), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_err",   32'(lsu_err_o), 32'd0);
      check("to_wait_stall", 32'(lsu_stall_req_o), 32'd1);
      step();
    end
    check("to_err_pulse", 32'(lsu_err_o), 32'd1);
    check("to_err_stall", 32'(lsu_stall_req_o), 32'd1);
    step();
    check("to_done_stall", 32'(lsu_stall_req_o), 32'd0);
    check("to_done_err",   32'(lsu_err_o), 32'd0);
    sb_check("to_data");
    lsu_req_i = 1'b0;
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
